instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
- Fetch stage that sits directly upstream of the word-addressed instruction memory (1024 x 32-bit, asynchronous read).
- Owns the program counter and drives the memory address.
- Registers the returned instruction into the IF/ID pipeline register for decode.
- Supports stall, branch/jump redirect with flush, and a halt state entered on a designated halt instruction.

Parameters:
- PC_WIDTH, 10, word-address width of PC and memory address.
- RESET_PC, 0, PC value loaded on reset.
- HALT_INSTR, 32'hFFFF_FFFF, instruction encoding that halts fetch.
- NOP_INSTR, 32'h0000_0000, value placed in ifid_instr on reset and flush.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC and IF/ID register this cycle.
- redirect_valid  in  1  branch/jump taken; load redirect_pc and flush.
- redirect_pc  in  PC_WIDTH  redirect target (word address).
- imem_addr  out  PC_WIDTH  address to instruction memory.
- imem_instr  in  32  instruction returned combinationally by memory.
- ifid_valid  out  1  IF/ID register holds a real instruction.
- ifid_pc  out  PC_WIDTH  PC of the instruction in IF/ID.
- ifid_instr  out  32  instruction in IF/ID.
- halted  out  1  fetch is in HALTED state.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst is asynchronous and active-high.
- Reset values (asserted immediately, not on a clock edge):
  - pc = RESET_PC
  - state = RUN
  - ifid_valid = 0
  - ifid_pc = 0
  - ifid_instr = NOP_INSTR
  - halted = 0
- Address path:
  - imem_addr = pc, combinational from the PC register.
  - The memory read is asynchronous, so imem_instr corresponds to pc in the same cycle.
- Latency: the instruction at address A appears in ifid_instr one clock edge after pc = A with no stall or redirect.
- Per-edge priority: rst > redirect_valid > stall > normal.
- States: RUN and HALTED. halted = (state == HALTED).
- Redirect (either state, stall ignored):
  - pc <= redirect_pc
  - ifid_valid <= 0, ifid_instr <= NOP_INSTR, ifid_pc <= pc
  - state <= RUN, which clears halt.
- Stall without redirect: pc, all ifid_* outputs and state hold their values.
- RUN, no stall, no redirect:
  - ifid_valid <= 1, ifid_pc <= pc, ifid_instr <= imem_instr.
  - If imem_instr != HALT_INSTR: pc <= pc + 1, wrapping modulo 2^PC_WIDTH (1023 -> 0, no flag).
  - If imem_instr == HALT_INSTR: the halt word is still passed to IF/ID with valid = 1; pc holds; state <= HALTED.
- HALTED, no stall, no redirect:
  - pc holds.
  - ifid_valid <= 0, ifid_instr <= NOP_INSTR, ifid_pc <= pc (bubbles).
  - Only a redirect or reset leaves HALTED.
- Simultaneous events:
  - redirect_valid with stall: the redirect wins; stall is ignored that cycle.
  - redirect_valid in the same cycle a halt word is fetched: the redirect wins; no halt is taken and the halt word is not passed to IF/ID.
- Reset mid-operation: all state returns to reset values asynchronously. Fetch restarts at RESET_PC on the first edge after rst deasserts.
- Combinational paths:
  - No combinational path from stall or redirect_* to any output.
  - imem_addr depends only on the PC register.

Test Plan:
- Reset then run, memory[i] = i + 32'h100:
  - During reset: imem_addr = 0, ifid_valid = 0.
  - Edges 1..3 after release: ifid_instr = 0x100, 0x101, 0x102 with ifid_pc = 0, 1, 2; imem_addr = 1, 2, 3.
- Stall held 3 cycles at pc = 5:
  - imem_addr stays 5; ifid_pc = 4 and ifid_instr hold for 3 cycles.
  - On the first unstalled edge: ifid_pc = 5, imem_addr = 6.
- Redirect to 0x3F0 while pc = 7, with stall = 1 in the same cycle:
  - Next cycle: imem_addr = 0x3F0, ifid_valid = 0, ifid_instr = 0.
  - Following cycle: ifid_pc = 0x3F0, ifid_valid = 1.
- Wrap-around from pc = 1022: imem_addr sequence 1022, 1023, 0, 1; ifid_pc follows one cycle later.
- HALT_INSTR at address 9:
  - ifid_instr = 0xFFFF_FFFF with valid = 1 and ifid_pc = 9.
  - Next cycle: halted = 1, imem_addr stays 9, ifid_valid = 0 on every following edge.
  - Redirect to 0: halted = 0, fetch resumes from 0.
- Assert rst mid-run at pc = 200 between clock edges:
  - imem_addr = 0, ifid_valid = 0 and halted = 0 immediately, before the next edge.
  - After release, the fetch sequence restarts from 0.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle.
// Groups the instruction-memory port, the pipeline control inputs
// (stall / redirect) and the IF/ID register outputs.
//   master : the fetch stage (drives imem_addr, ifid_*, halted)
//   slave  : the surrounding pipeline and memory (drives stall,
//            redirect_*, imem_instr)
interface instruction_fetch_if #(
  parameter int PC_WIDTH = 10
);
  logic                stall;
  logic                redirect_valid;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic [PC_WIDTH-1:0] imem_addr;
  logic [31:0]         imem_instr;
  logic                ifid_valid;
  logic [PC_WIDTH-1:0] ifid_pc;
  logic [31:0]         ifid_instr;
  logic                halted;

  modport master (
    input  stall, redirect_valid, redirect_pc, imem_instr,
    output imem_addr, ifid_valid, ifid_pc, ifid_instr, halted
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, imem_instr,
    input  imem_addr, ifid_valid, ifid_pc, ifid_instr, halted
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage.
// Owns the PC, addresses an asynchronous-read instruction memory and
// registers the returned word into the IF/ID pipeline register.
// Supports stall, redirect with flush, and a HALTED state entered when
// the halt encoding is fetched.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   fif  : instruction_fetch_if.master
//          stall, redirect_valid, redirect_pc, imem_instr (in)
//          imem_addr, ifid_valid, ifid_pc, ifid_instr, halted (out)
module instruction_fetch #(
  parameter int                  PC_WIDTH   = 10,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [31:0]         HALT_INSTR = 32'hFFFF_FFFF,
  parameter logic [31:0]         NOP_INSTR  = 32'h0000_0000
) (
  input logic                 clk,
  input logic                 rst,
  instruction_fetch_if.master fif
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  state_t              state_p0, state_nxt;
  logic [PC_WIDTH-1:0] pc_p0, pc_nxt;
  logic                vld_p1, vld_nxt;
  logic [PC_WIDTH-1:0] ifid_pc_p1, ifid_pc_nxt;
  logic [31:0]         instr_p1, instr_nxt;

  // Priority: redirect > stall > normal fetch. Defaults hold everything,
  // which is exactly the stall behaviour.
  always_comb begin
    state_nxt   = state_p0;
    pc_nxt      = pc_p0;
    vld_nxt     = vld_p1;
    ifid_pc_nxt = ifid_pc_p1;
    instr_nxt   = instr_p1;
    if (fif.redirect_valid) begin
      // Flush: the word at the old PC is discarded, halt (if any) cleared.
      state_nxt   = RUN;
      pc_nxt      = fif.redirect_pc;
      vld_nxt     = 1'b0;
      ifid_pc_nxt = pc_p0;
      instr_nxt   = NOP_INSTR;
    end else if (!fif.stall) begin
      case (state_p0)
        RUN: begin
          vld_nxt     = 1'b1;
          ifid_pc_nxt = pc_p0;
          instr_nxt   = fif.imem_instr;
          // The halt word itself goes down the pipe; PC parks on it.
          if (fif.imem_instr == HALT_INSTR) begin
            state_nxt = HALTED;
          end else begin
            pc_nxt = pc_p0 + PC_ONE;
          end
        end
        HALTED: begin
          vld_nxt     = 1'b0;
          ifid_pc_nxt = pc_p0;
          instr_nxt   = NOP_INSTR;
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

  // ---- PC / state (p0) -> IF/ID register (p1) ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0   <= RUN;
      pc_p0      <= RESET_PC;
      vld_p1     <= 1'b0;
      ifid_pc_p1 <= '0;
      instr_p1   <= NOP_INSTR;
    end else begin
      state_p0   <= state_nxt;
      pc_p0      <= pc_nxt;
      vld_p1     <= vld_nxt;
      ifid_pc_p1 <= ifid_pc_nxt;
      instr_p1   <= instr_nxt;
    end
  end

  assign fif.imem_addr  = pc_p0;
  assign fif.ifid_valid = vld_p1;
  assign fif.ifid_pc    = ifid_pc_p1;
  assign fif.ifid_instr = instr_p1;
  assign fif.halted     = (state_p0 == HALTED);

endmodule
